// File: rtl/cyclic_left_rotator_serial.sv
// -----------------------------------------------------------------------------
// cyclic_left_rotator_serial
//
// Serial cyclic left rotator. It is the inverse of the datapath's cyclic
// right-shift register stage: a word rotated right by k and then passed
// through this block with amount k comes back unchanged.
//
// A WIDTH-bit word and a rotate amount are accepted over a valid/ready
// handshake. The word is rotated left by one bit per clock, and the result is
// returned over a second valid/ready handshake.
//
// Ports
//   clock      in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      request valid
//   in_ready   out  1      block can accept a request (state IDLE)
//   in_data    in   WIDTH  word to rotate
//   in_amount  in   AMT_W  left-rotate amount, 0..WIDTH-1
//   out_valid  out  1      result valid (state DONE)
//   out_ready  in   1      consumer accepts result
//   out_data   out  WIDTH  rotated word (working register, shows
//                          intermediate values while shifting)
//   busy       out  1      high while shifting or holding a result
//
// Timing: a request accepted at edge t0 with amount N produces out_valid
// after edge t0+N. An amount of 0 goes straight to DONE. The result handshake
// always returns to IDLE first, so back-to-back requests complete once every
// N+2 cycles.
// -----------------------------------------------------------------------------
module cyclic_left_rotator_serial #(
  parameter int WIDTH = 128,
  parameter int AMT_W = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic [AMT_W-1:0] cnt;
  logic [AMT_W-1:0] cnt_next;

  // ---------------------------------------------------------------------------
  // Next-state and datapath decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal is given a hold value before the case statement.
    // Any path that leaves a combinational output unassigned infers a latch.
    state_next = state;
    q_next     = q;
    cnt_next   = cnt;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          q_next     = in_data;
          cnt_next   = in_amount;
          // A zero amount needs no rotation, so the word is already the result.
          state_next = (in_amount == '0) ? DONE : SHIFT;
        end
      end

      SHIFT: begin
        // Rotate left by one: the MSB wraps around into bit 0.
        q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
        cnt_next = cnt - 1'b1;
        // cnt is never 0 here, because IDLE routes a zero amount straight to
        // DONE. The last rotate happens when cnt is 1, so cnt stops at 0 and
        // never underflows.
        if (cnt == AMT_W'(1)) begin
          state_next = DONE;
        end
      end

      DONE: begin
        // The result is held until the consumer accepts it. A request that
        // arrives in the same cycle waits until the block is back in IDLE.
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples its inputs from before the edge, whatever order
    // the always blocks are evaluated in.
    if (reset) begin
      state <= IDLE;
      q     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      q     <= q_next;
      cnt   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from registered state only
  // ---------------------------------------------------------------------------
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = !in_ready;
  assign out_data  = q;

endmodule
